// File: rtl/riscv_core_mem_read_arbiter.sv
// Refill arbiter: shares the single AXI read channel between the data-cache
// and instruction-cache refill controllers. The winner's line-aligned address
// is latched, the grant is held for the whole refill, and the completion pulse
// is routed back to the owner only. A one-cycle RELEASE guard follows every
// refill so the served requester can lower its level request.
module riscv_core_mem_read_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    // data-cache refill port
    input  logic                  i_dc_req,
    input  logic [ADDR_WIDTH-1:0] i_dc_addr,
    output logic                  o_dc_done,
    output logic [LINE_WIDTH-1:0] o_dc_line,

    // instruction-cache refill port
    input  logic                  i_ic_req,
    input  logic [ADDR_WIDTH-1:0] i_ic_addr,
    output logic                  o_ic_done,
    output logic [LINE_WIDTH-1:0] o_ic_line,

    // AXI read-channel master side
    output logic                  o_axi_req,
    output logic [ADDR_WIDTH-1:0] o_axi_addr,
    input  logic                  i_axi_done,
    input  logic [LINE_WIDTH-1:0] i_axi_line,

    // status
    output logic                  o_owner,
    output logic                  o_busy
);

    localparam logic OWNER_DC = 1'b0;
    localparam logic OWNER_IC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_served_q, last_served_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    logic                    pick_ic;
    logic                    in_busy;

    // Offset bits of the request addresses are discarded by line alignment.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_dc_addr[OFFSET_BITS-1:0], i_ic_addr[OFFSET_BITS-1:0]};

    // Clear the line-offset bits so the AXI master always fetches whole lines.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        pick_ic = i_ic_req & (~i_dc_req | (last_served_q == OWNER_DC));
    end

    // State, owner, round-robin pointer and latched address registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_DC;
            last_served_q <= OWNER_IC;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            addr_q        <= addr_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for completion in BUSY, guard in RELEASE.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        addr_d        = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_dc_req || i_ic_req) begin
                    owner_d = pick_ic ? OWNER_IC : OWNER_DC;
                    addr_d  = pick_ic ? line_align(i_ic_addr) : line_align(i_dc_addr);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_axi_done) begin
                    last_served_d = owner_q;
                    state_d       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request drops in the completion cycle itself; done is routed to the owner only.
    always_comb begin
        in_busy    = (state_q == ST_BUSY);
        o_busy     = in_busy;
        o_owner    = owner_q;
        o_axi_req  = in_busy & ~i_axi_done;
        o_axi_addr = addr_q;
        o_dc_done  = in_busy & (owner_q == OWNER_DC) & i_axi_done;
        o_ic_done  = in_busy & (owner_q == OWNER_IC) & i_axi_done;
        o_dc_line  = i_axi_line;
        o_ic_line  = i_axi_line;
    end

endmodule

// File: tb/tb_riscv_core_mem_read_arbiter.sv
// Scoreboard bench for the refill arbiter: stimulus pushes expected grants,
// an AXI responder answers with random latency, a monitor pops and checks.
module tb_riscv_core_mem_read_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned LW = 256;
    localparam int unsigned OB = 5;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_dc_req, i_ic_req;
    logic [AW-1:0] i_dc_addr, i_ic_addr;
    logic          o_dc_done, o_ic_done;
    logic [LW-1:0] o_dc_line, o_ic_line;
    logic          o_axi_req;
    logic [AW-1:0] o_axi_addr;
    logic          i_axi_done;
    logic [LW-1:0] i_axi_line;
    logic          o_owner, o_busy;

    riscv_core_mem_read_arbiter #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .OFFSET_BITS(OB)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_dc_req  (i_dc_req),
        .i_dc_addr (i_dc_addr),
        .o_dc_done (o_dc_done),
        .o_dc_line (o_dc_line),
        .i_ic_req  (i_ic_req),
        .i_ic_addr (i_ic_addr),
        .o_ic_done (o_ic_done),
        .o_ic_line (o_ic_line),
        .o_axi_req (o_axi_req),
        .o_axi_addr(o_axi_addr),
        .i_axi_done(i_axi_done),
        .i_axi_line(i_axi_line),
        .o_owner   (o_owner),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic          owner;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic ls       = 1'b1;   // model's last-served requester (1 = icache)
    int   fixed_lat = 0;     // 0 = random responder latency
    bit   a5_mode   = 1'b0;
    int   spur_req  = 0;
    int   cyc       = 0;
    int   last_gap  = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~((AW'(1) << OB) - AW'(1));
    endfunction

    task automatic push(input logic own, input logic [AW-1:0] a);
        exp_t e;
        e.owner = own;
        e.addr  = align(a);
        exp_q.push_back(e);
    endtask

    // AXI read responder: answers each request after a latency with a one-cycle done.
    initial begin
        bit pending = 1'b0;
        int cnt = 0;
        int spur_ack = 0;
        i_axi_done = 1'b0;
        i_axi_line = '0;
        forever begin
            @(posedge i_clk);
            #1;
            if (!i_rst_n) begin
                pending = 1'b0;
                i_axi_done = 1'b0;
            end else if (i_axi_done) begin
                i_axi_done = 1'b0;
            end else if (!pending && o_axi_req) begin
                pending = 1'b1;
                cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending = 1'b0;
                    i_axi_done = 1'b1;
                    if (a5_mode) i_axi_line = {32{8'hA5}};
                    else for (int i = 0; i < 8; i++) i_axi_line[i*32 +: 32] = $urandom;
                end
            end else if (spur_req != spur_ack && !o_busy && !o_axi_req) begin
                spur_ack = spur_req;
                i_axi_done = 1'b1;
                for (int i = 0; i < 8; i++) i_axi_line[i*32 +: 32] = $urandom;
            end
        end
    end

    // Monitor: pops an expected grant when a request starts, checks routing at done.
    initial begin
        bit   active = 1'b0;
        exp_t cur;
        int   last_done = -100;
        cur = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (!i_rst_n) begin
                active = 1'b0;
                last_done = -100;
                continue;
            end
            if (!active) begin
                chk("idle_done", LW'({o_dc_done, o_ic_done}), LW'(2'b00));
                if (o_axi_req) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", LW'(o_axi_req), LW'(1'b0));
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_owner", LW'(o_owner), LW'(cur.owner));
                        chk("grant_addr", LW'(o_axi_addr), LW'(cur.addr));
                        last_gap = cyc - last_done;
                        chk("grant_gap_min", LW'(last_gap >= 3), LW'(1'b1));
                        active = 1'b1;
                    end
                end
            end else begin
                chk("busy", LW'(o_busy), LW'(1'b1));
                chk("addr_hold", LW'(o_axi_addr), LW'(cur.addr));
                if (o_dc_done || o_ic_done) begin
                    chk("done_route", LW'({o_dc_done, o_ic_done}),
                        LW'(cur.owner ? 2'b01 : 2'b10));
                    chk("line", cur.owner ? o_ic_line : o_dc_line, i_axi_line);
                    chk("req_drop", LW'(o_axi_req), LW'(1'b0));
                    active = 1'b0;
                    last_done = cyc;
                end else begin
                    chk("req_held", LW'(o_axi_req), LW'(1'b1));
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_axi_req"}, LW'(o_axi_req), LW'(1'b0));
        chk({nm, "_axi_addr"}, LW'(o_axi_addr), LW'(0));
        chk({nm, "_dones"}, LW'({o_dc_done, o_ic_done}), LW'(2'b00));
        chk({nm, "_busy"}, LW'(o_busy), LW'(1'b0));
        chk({nm, "_owner"}, LW'(o_owner), LW'(1'b0));
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 chk_all_zero("midbusy_rst");
        i_dc_req = 1'b0;
        i_ic_req = 1'b0;
        exp_q.delete();
        ls = 1'b1;
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
    endtask

    // mode: 0 normal, 1 icache arrives during dcache refill, 2 dcache address
    // changes mid-refill, 3 dcache abandons its request, 4 reset mid-refill
    task automatic episode(input bit dc_en, input bit ic_en, input logic [AW-1:0] da,
                           input logic [AW-1:0] ia, input int mode, input int lat);
        bit got_dc, got_ic, ic_up;
        logic first;
        fixed_lat = lat;
        repeat (3) @(negedge i_clk);
        i_dc_addr = da;
        i_ic_addr = ia;
        if (dc_en && ic_en && mode != 1) begin
            first = ~ls;
            push(first, first ? ia : da);
            push(~first, first ? da : ia);
            ls = ~first;
        end else begin
            if (dc_en) begin push(1'b0, da); ls = 1'b0; end
            if (ic_en) begin push(1'b1, ia); ls = 1'b1; end
        end
        i_dc_req = dc_en;
        i_ic_req = ic_en && (mode != 1);
        got_dc = !dc_en;
        got_ic = !ic_en;
        ic_up  = (mode != 1);
        for (int n = 0; n < 400 && !(got_dc && got_ic); n++) begin
            @(negedge i_clk);
            if (n == 0) chk("grant_latency", LW'(o_axi_req), LW'(1'b1));
            if (o_dc_done) begin i_dc_req = 1'b0; got_dc = 1'b1; end
            if (o_ic_done) begin i_ic_req = 1'b0; got_ic = 1'b1; end
            if (o_busy && !o_dc_done && !o_ic_done) begin
                if (!ic_up) begin i_ic_req = 1'b1; ic_up = 1'b1; end
                if (mode == 2) i_dc_addr = 64'h2000;
                if (mode == 3) i_dc_req = 1'b0;
                if (mode == 4 && n >= 2) begin
                    do_reset();
                    return;
                end
            end
        end
        if (!(got_dc && got_ic)) begin
            chk("episode_timeout", LW'({got_dc, got_ic}), LW'(2'b11));
            i_dc_req = 1'b0;
            i_ic_req = 1'b0;
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_dc_req  = 1'b0;
        i_ic_req  = 1'b0;
        i_dc_addr = '0;
        i_ic_addr = '0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_all_zero("post_reset");

        // single dcache miss, 4-cycle latency, A5 line
        a5_mode = 1'b1;
        episode(1'b1, 1'b0, 64'h0000_1234_5678_9ABC, '0, 0, 4);
        a5_mode = 1'b0;

        // reset again so the tie below starts from the reset round-robin pointer
        do_reset();

        // simultaneous held requests: dc, ic, then dc, ic again
        episode(1'b1, 1'b1, 64'h0000_0000_0000_1040, 64'h0000_0000_0008_0077, 0, 0);
        chk("b2b_gap", LW'(last_gap), LW'(3));
        episode(1'b1, 1'b1, 64'h0000_0000_0000_2fff, 64'h0000_0000_0009_0001, 0, 0);
        chk("b2b_gap2", LW'(last_gap), LW'(3));

        // icache arrives during a dcache refill
        episode(1'b1, 1'b1, 64'h0000_0000_0000_3000, 64'h0000_0000_000a_0020, 1, 5);
        chk("late_ic_gap", LW'(last_gap), LW'(3));

        // dcache changes its address during BUSY
        episode(1'b1, 1'b0, 64'h0000_0000_dead_beef, '0, 2, 5);

        // dcache abandons its request; done still comes back to it
        episode(1'b1, 1'b0, 64'h0000_0000_0000_5555, '0, 3, 4);

        // spurious done while idle
        repeat (3) @(negedge i_clk);
        spur_req++;
        repeat (5) @(negedge i_clk);
        chk("spur_busy", LW'(o_busy), LW'(1'b0));
        chk("spur_req", LW'(o_axi_req), LW'(1'b0));
        chk("spur_queue", LW'(exp_q.size()), LW'(0));

        // reset during a refill, then a tie goes to dcache
        episode(1'b0, 1'b1, '0, 64'h0000_0000_0000_7780, 4, 6);
        episode(1'b1, 1'b1, 64'h0000_0000_0000_8800, 64'h0000_0000_0000_9900, 0, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            int r;
            int m;
            r = int'($urandom_range(1, 3));
            m = (r == 1 && $urandom_range(0, 3) == 0) ? 3 : 0;
            episode(r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom}, m, 0);
        end

        repeat (5) @(negedge i_clk);
        chk("final_queue_empty", LW'(exp_q.size()), LW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/riscv_core_mem_read_arbiter.md
# riscv_core_mem_read_arbiter

Arbitrates cache-line refill requests from the data-cache controller and the instruction-cache controller onto the single AXI read channel. Each requester sees a private req/done/line interface. The arbiter latches the winner's line address, holds the grant for the whole refill, and routes the completion pulse and line data back to the owner only. It sits between the two cache controllers and the AXI read-channel master.

## Interface
- ADDR_WIDTH, 64, byte address width
- LINE_WIDTH, 256, refill line width (matches AXI_DATA_WIDTH)
- OFFSET_BITS, 5, line-offset bits forced to zero on the outgoing address
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_dc_req  in  1  data-cache refill request, level; held until o_dc_done
- i_dc_addr  in  ADDR_WIDTH  data-cache miss address
- o_dc_done  out  1  one-cycle refill-complete pulse to the data cache
- o_dc_line  out  LINE_WIDTH  refill line; valid only while o_dc_done=1
- i_ic_req, i_ic_addr, o_ic_done, o_ic_line: same as the dc_ versions, for the instruction cache
- o_axi_req  out  1  read request to the AXI read channel, level
- o_axi_addr  out  ADDR_WIDTH  latched line-aligned address
- i_axi_done  in  1  one-cycle read-complete pulse
- i_axi_line  in  LINE_WIDTH  returned line, valid with i_axi_done
- o_owner  out  1  current or last grant owner: 0 = dcache, 1 = icache
- o_busy  out  1  high in the BUSY state

## Operation
- States: IDLE, BUSY, RELEASE. Registers: state, owner, last_served (round-robin pointer), addr_q.
- IDLE with no requests: stay in IDLE.
- IDLE with exactly one request: grant it. Set owner, latch addr_q = {addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'b0}, go to BUSY.
- IDLE with both requests: grant the requester that is not last_served. After reset, last_served = icache, so dcache wins the first tie.
- BUSY:
  - o_axi_req = ~i_axi_done, so the request drops combinationally in the done cycle.
  - o_axi_addr = addr_q.
  - On i_axi_done: pulse the owner's done output, set last_served = owner, go to RELEASE.
- RELEASE: one guard cycle with all requests ignored and o_axi_req=0, then go to IDLE. This lets the served requester lower its req.
- Data routing:
  - o_dc_line and o_ic_line are driven from i_axi_line unconditionally.
  - Each done output equals (state==BUSY) & (owner==that requester) & i_axi_done.
  - The non-owner's done is never asserted.
- Abandoned request: if the owner drops req during BUSY, the AXI transaction still completes. The done pulse is still routed to the owner, and the owner ignores it. There is no cancel path.
- An address change on the owner's port during BUSY has no effect; addr_q is used.
- Requests arriving during BUSY or RELEASE wait. Their requester sees no done and stays stalled.
- i_axi_done outside BUSY is ignored: no done output, no state change.

## Timing
- Reset values:
  - state = IDLE, owner = 0, last_served = 1, addr_q = 0.
  - o_axi_req = 0, o_axi_addr = 0, o_dc_done = 0, o_ic_done = 0, o_busy = 0, o_owner = 0.
- Reset asserted mid-BUSY: return to IDLE immediately and drop o_axi_req. Downstream is reset by the same i_rst_n.
- Grant latency: req seen high at edge N, then o_axi_req=1 and o_axi_addr valid from cycle N+1.
- Done latency: i_axi_done in cycle M gives o_x_done in cycle M (combinational). RELEASE occupies M+1, IDLE is entered at M+2, and the earliest next grant is the edge ending M+2.
- Back-to-back cost: one RELEASE cycle plus one IDLE cycle between transactions.
- Under continuous requests from both ports, grants strictly alternate. Worst-case wait is one full refill plus 2 cycles.

## Test plan
- Single dcache miss:
  - Stimulus: i_dc_req=1, i_dc_addr=0x0000_1234_5678_9ABC; i_axi_done 4 cycles after o_axi_req rises, i_axi_line=0xA5 pattern.
  - Response: o_axi_addr=0x...9AA0; o_dc_done for one cycle with o_dc_line=0xA5 pattern; o_ic_done stays 0; o_axi_req falls in the done cycle.
- Simultaneous requests after reset, both held:
  - Stimulus: i_dc_req and i_ic_req assert together and stay high.
  - Response: grant order is dcache, icache, dcache; o_owner toggles 0, 1, 0; each transaction's o_axi_addr matches its own requester.
- Icache request arrives while a dcache refill is in flight:
  - Stimulus: i_ic_req rises during a dcache refill.
  - Response: no icache grant until 2 cycles after the dcache done; the icache is granted next.
- Owner changes its address mid-BUSY:
  - Stimulus: i_dc_addr changes to 0x2000 during BUSY.
  - Response: o_axi_addr keeps the original latched value.
- Spurious done:
  - Stimulus: i_axi_done pulses while in IDLE.
  - Response: no done outputs, state unchanged.
- Reset during a refill:
  - Stimulus: i_rst_n=0 mid-BUSY.
  - Response: all outputs 0 immediately. After release, a tie is granted to the dcache.
